// File: rtl/dmem_responder.sv
// Data-memory responder for a no-stall CPU: word RAM plus MMIO (LED, TX byte FIFO, status, cycle counter).
// Optional cycle counter is enabled by defining DMEM_CYCLE_COUNTER_EN.
module dmem_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int RAM_DEPTH_LOG2  = 10,
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int LED_WIDTH       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cpuAddr,
    input  logic [DATA_WIDTH-1:0] cpuWrData,
    input  logic                  cpuWrEnable,
    output logic [DATA_WIDTH-1:0] cpuRdData,
    output logic [LED_WIDTH-1:0]  ledOut,
    output logic                  txValid,
    output logic [7:0]            txData,
    input  logic                  txReady
);
    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int OFF_W      = ADDR_WIDTH - 1;
    localparam logic [OFF_W-1:0] OFF_LED    = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_TX     = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_STATUS = OFF_W'(2);
    localparam logic [OFF_W-1:0] OFF_CYCLE  = OFF_W'(3);

    logic [DATA_WIDTH-1:0]      ram_q  [2**RAM_DEPTH_LOG2];
    logic [7:0]                 fifo_q [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic                       overflow_q, overflow_d;
    logic [LED_WIDTH-1:0]       led_q, led_d;
    logic [DATA_WIDTH-1:0]      cycle_rd;

    logic                      is_mmio;
    logic [OFF_W-1:0]          off;
    logic                      st_led, st_tx, st_status;
    logic                      full, empty, pop, push;
    logic [DATA_WIDTH-1:0]     status;

    assign is_mmio   = cpuAddr[ADDR_WIDTH-1];
    assign off       = cpuAddr[OFF_W-1:0];
    assign st_led    = cpuWrEnable && is_mmio && (off == OFF_LED);
    assign st_tx     = cpuWrEnable && is_mmio && (off == OFF_TX);
    assign st_status = cpuWrEnable && is_mmio && (off == OFF_STATUS);

    assign full  = (count_q == (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = txValid && txReady;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push  = st_tx && (!full || pop);

    assign txValid = !empty;
    assign txData  = empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign ledOut  = led_q;
    assign status  = {overflow_q, full, empty,
                      {(DATA_WIDTH - 3 - FIFO_DEPTH_LOG2 - 1){1'b0}}, count_q};

    always_comb begin
        led_d      = led_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (st_led)
            led_d = cpuWrData[LED_WIDTH-1:0];
        if (st_status)
            overflow_d = 1'b0;
        else if (st_tx && full && !pop)
            overflow_d = 1'b1;
        if (push)
            wr_ptr_d = wr_ptr_q + FIFO_DEPTH_LOG2'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + FIFO_DEPTH_LOG2'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q      <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            led_q      <= led_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage arrays carry no reset; RAM stores are honoured even during reset.
    always_ff @(posedge clk) begin
        if (cpuWrEnable && !is_mmio)
            ram_q[cpuAddr[RAM_DEPTH_LOG2-1:0]] <= cpuWrData;
        if (!rst && push)
            fifo_q[wr_ptr_q] <= cpuWrData[7:0];
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_q, cycle_d;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (cpuWrEnable && is_mmio && (off == OFF_CYCLE))
            cycle_d = cpuWrData;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cycle_q <= '0;
        else
            cycle_q <= cycle_d;
    end

    assign cycle_rd = cycle_q;
`else
    assign cycle_rd = '0;
`endif

    always_comb begin
        cpuRdData = '0;
        if (!is_mmio) begin
            cpuRdData = ram_q[cpuAddr[RAM_DEPTH_LOG2-1:0]];
        end else begin
            case (off)
                OFF_LED:    cpuRdData = DATA_WIDTH'(led_q);
                OFF_STATUS: cpuRdData = status;
                OFF_CYCLE:  cpuRdData = cycle_rd;
                default:    cpuRdData = '0;
            endcase
        end
    end
endmodule
